// File: rtl/jk_pkg.sv
// Mode encoding shared by the JK counter/register bank and its cells.
// Pure constants; no logic, no latency, no flow control.
package jk_pkg;
  localparam logic [1:0] MODE_JK = 2'b00;
  localparam logic [1:0] MODE_UP = 2'b01;
  localparam logic [1:0] MODE_DN = 2'b10;
  localparam logic [1:0] MODE_LD = 2'b11;
endpackage

// File: rtl/jk_ff_cell.sv
// Single JK flip-flop with synchronous reset to rst_val and a hold-enable.
// One-cycle latency from j/k to q; en=0 holds state, no other backpressure.
module jk_ff_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic j,
  input  logic k,
  input  logic rst_val,
  output logic q,
  output logic qbar
);
  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case ({j, k})
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      2'b11:   q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= rst_val;
    end else if (en) begin
      q_q <= q_d;
    end
  end

  // One state bit only, so qbar can never disagree with q.
  assign q    = q_q;
  assign qbar = ~q_q;
endmodule

// File: rtl/jk_counter_reg.sv
// WIDTH JK cells steered as per-bit JK, up/down counter or parallel load.
// State updates one cycle after sampling; tc is combinational; en=0 holds all cells.
module jk_counter_reg
  import jk_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter bit               WRAP    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             tc
);
  logic [WIDTH-1:0] all_ones;
  logic [WIDTH-1:0] all_zeros;
  logic [WIDTH-1:0] j_cell;
  logic [WIDTH-1:0] k_cell;
  logic             sat;

  // Bit i toggles when every lower bit is 1 (up) or 0 (down); bit 0 always toggles.
  assign all_ones[0]  = 1'b1;
  assign all_zeros[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_chain
    assign all_ones[i]  = all_ones[i-1]  & Q[i-1];
    assign all_zeros[i] = all_zeros[i-1] & ~Q[i-1];
  end

  always_comb begin
    tc = 1'b0;
    case (mode)
      MODE_UP: tc = &Q;
      MODE_DN: tc = ~|Q;
      default: tc = 1'b0;
    endcase
  end

  assign sat = !WRAP && tc;

  always_comb begin
    j_cell = '0;
    k_cell = '0;
    case (mode)
      MODE_JK: begin
        j_cell = J;
        k_cell = K;
      end
      MODE_UP: begin
        if (!sat) begin
          j_cell = all_ones;
          k_cell = all_ones;
        end
      end
      MODE_DN: begin
        if (!sat) begin
          j_cell = all_zeros;
          k_cell = all_zeros;
        end
      end
      default: begin
        j_cell = D;
        k_cell = ~D;
      end
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_ff_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .j       (j_cell[i]),
      .k       (k_cell[i]),
      .rst_val (RST_VAL[i]),
      .q       (Q[i]),
      .qbar    (Qbar[i])
    );
  end
endmodule

// File: tb/tb_jk_counter_reg.sv
// Bench for jk_counter_reg: a wrapping and a saturating instance share stimulus
// and are compared against an arithmetic reference model after every edge.
module tb_jk_counter_reg;
  localparam logic [3:0] RV = 4'b1010;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [1:0] mode;
  logic [3:0] J, K, D;
  logic [3:0] Qw, Qbw, Qs, Qbs;
  logic       tcw, tcs;

  logic [3:0] mw, ms;
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  jk_counter_reg #(.WIDTH(4), .RST_VAL(RV), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .J(J), .K(K), .D(D),
    .Q(Qw), .Qbar(Qbw), .tc(tcw)
  );

  jk_counter_reg #(.WIDTH(4), .RST_VAL(RV), .WRAP(1'b0)) dut_s (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .J(J), .K(K), .D(D),
    .Q(Qs), .Qbar(Qbs), .tc(tcs)
  );

  function automatic logic [3:0] model_next(logic [3:0] q, bit wrap, logic r, logic e,
                                            logic [1:0] m, logic [3:0] jj, logic [3:0] kk,
                                            logic [3:0] dd);
    logic [3:0] n;
    if (r) return RV;
    if (!e) return q;
    n = q;
    case (m)
      2'd0: for (int b = 0; b < 4; b++) begin
        if (jj[b] && kk[b]) n[b] = ~q[b];
        else if (jj[b])     n[b] = 1'b1;
        else if (kk[b])     n[b] = 1'b0;
      end
      2'd1: n = (!wrap && q == 4'd15) ? q : 4'((int'(q) + 1) % 16);
      2'd2: n = (!wrap && q == 4'd0)  ? q : 4'((int'(q) + 15) % 16);
      default: n = dd;
    endcase
    return n;
  endfunction

  function automatic logic model_tc(logic [3:0] q, logic [1:0] m);
    return (m == 2'd1 && q == 4'd15) || (m == 2'd2 && q == 4'd0);
  endfunction

  task automatic clk_edge();
    mw = model_next(mw, 1'b1, rst, en, mode, J, K, D);
    ms = model_next(ms, 1'b0, rst, en, mode, J, K, D);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 2'd0; J = '0; K = '0; D = '0;
    clk_edge();
    n_checks++; if (Qw !== 4'hA) $display("FAIL reset_q got %h want a", Qw); else n_pass++;
    n_checks++; if (Qbw !== 4'h5) $display("FAIL reset_qbar got %h want 5", Qbw); else n_pass++;
    n_checks++; if (Qs !== 4'hA) $display("FAIL reset_q_sat got %h want a", Qs); else n_pass++;
    rst = 1'b0; mode = 2'd3; D = 4'h3;
    clk_edge();
    n_checks++; if (Qw !== 4'h3) $display("FAIL load3 got %h want 3", Qw); else n_pass++;
    rst = 1'b1; en = 1'b0; mode = 2'd1;
    clk_edge();
    n_checks++; if (Qw !== 4'hA) $display("FAIL reset_en0_q got %h want a", Qw); else n_pass++;
    n_checks++; if (Qbw !== 4'h5) $display("FAIL reset_en0_qbar got %h want 5", Qbw); else n_pass++;
    n_checks++; if (tcw !== 1'b0) $display("FAIL reset_tc got %b want 0", tcw); else n_pass++;
    rst = 1'b0; en = 1'b1;
  endtask

  task automatic test_jk_table();
    mode = 2'd3; D = 4'b0110;
    clk_edge();
    mode = 2'd0; J = 4'b0011; K = 4'b0101; D = 4'b1111;
    clk_edge();
    n_checks++; if (Qw !== 4'b0011) $display("FAIL jk_q got %b want 0011", Qw); else n_pass++;
    n_checks++; if (Qbw !== 4'b1100) $display("FAIL jk_qbar got %b want 1100", Qbw); else n_pass++;
    n_checks++; if (tcw !== 1'b0) $display("FAIL jk_tc got %b want 0", tcw); else n_pass++;
  endtask

  task automatic test_up_wrap();
    logic [3:0] exp_q [4] = '{4'hE, 4'hF, 4'h0, 4'h1};
    logic       exp_t [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    mode = 2'd3; D = 4'hD;
    clk_edge();
    mode = 2'd1;
    for (int i = 0; i < 4; i++) begin
      clk_edge();
      n_checks++; if (Qw !== exp_q[i]) $display("FAIL up_q[%0d] got %h want %h", i, Qw, exp_q[i]); else n_pass++;
      n_checks++; if (tcw !== exp_t[i]) $display("FAIL up_tc[%0d] got %b want %b", i, tcw, exp_t[i]); else n_pass++;
    end
  endtask

  task automatic test_down_sat();
    logic [3:0] exp_s [4] = '{4'h1, 4'h0, 4'h0, 4'h0};
    logic       exp_t [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] exp_w [4] = '{4'h1, 4'h0, 4'hF, 4'hE};
    mode = 2'd3; D = 4'h2;
    clk_edge();
    mode = 2'd2;
    for (int i = 0; i < 4; i++) begin
      clk_edge();
      n_checks++; if (Qs !== exp_s[i]) $display("FAIL dn_sat_q[%0d] got %h want %h", i, Qs, exp_s[i]); else n_pass++;
      n_checks++; if (tcs !== exp_t[i]) $display("FAIL dn_sat_tc[%0d] got %b want %b", i, tcs, exp_t[i]); else n_pass++;
      n_checks++; if (Qw !== exp_w[i]) $display("FAIL dn_wrap_q[%0d] got %h want %h", i, Qw, exp_w[i]); else n_pass++;
    end
    mode = 2'd3; D = 4'h5;
    clk_edge();
    n_checks++; if (Qs !== 4'h5) $display("FAIL sat_load got %h want 5", Qs); else n_pass++;
    n_checks++; if (tcs !== 1'b0) $display("FAIL sat_load_tc got %b want 0", tcs); else n_pass++;
  endtask

  task automatic test_enable_reset();
    mode = 2'd3; D = 4'h3;
    clk_edge();
    mode = 2'd1; en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      clk_edge();
      n_checks++; if (Qw !== 4'h3) $display("FAIL en_hold[%0d] got %h want 3", i, Qw); else n_pass++;
    end
    en = 1'b1; rst = 1'b1;
    clk_edge();
    n_checks++; if (Qw !== 4'hA) $display("FAIL midcount_rst got %h want a", Qw); else n_pass++;
    n_checks++; if (Qs !== 4'hA) $display("FAIL midcount_rst_sat got %h want a", Qs); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_random();
    rst = 1'b1; en = 1'b1;
    clk_edge();
    for (int c = 0; c < 1000; c++) begin
      rst  = ($urandom_range(0, 31) == 0);
      en   = ($urandom_range(0, 4) != 0);
      mode = 2'($urandom_range(0, 3));
      J    = 4'($urandom);
      K    = 4'($urandom);
      D    = 4'($urandom);
      clk_edge();
      n_checks++; if (Qw !== mw) $display("FAIL rnd_q_wrap c=%0d got %h want %h", c, Qw, mw); else n_pass++;
      n_checks++; if (Qs !== ms) $display("FAIL rnd_q_sat c=%0d got %h want %h", c, Qs, ms); else n_pass++;
      n_checks++; if (Qbw !== ~mw) $display("FAIL rnd_qbar_wrap c=%0d got %h want %h", c, Qbw, ~mw); else n_pass++;
      n_checks++; if (Qbs !== ~ms) $display("FAIL rnd_qbar_sat c=%0d got %h want %h", c, Qbs, ~ms); else n_pass++;
      n_checks++; if (tcw !== model_tc(mw, mode)) $display("FAIL rnd_tc_wrap c=%0d got %b want %b", c, tcw, model_tc(mw, mode)); else n_pass++;
      n_checks++; if (tcs !== model_tc(ms, mode)) $display("FAIL rnd_tc_sat c=%0d got %b want %b", c, tcs, model_tc(ms, mode)); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; J = '0; K = '0; D = '0;
    mw = RV; ms = RV;
    test_reset();
    test_jk_table();
    test_up_wrap();
    test_down_sat();
    test_enable_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/jk_counter_reg.md
# jk_counter_reg

Parametrised register bank of WIDTH JK flip-flop cells with selectable operating mode: independent per-bit JK, synchronous up-count, synchronous down-count, or parallel load. It succeeds the single-bit JK flip-flop in the sequential-logic library and is the building block for lab counters and the control registers in the datapath. Every mode is realised by driving per-cell J/K inputs, so all state lives in JK cells. Qbar is always the exact complement of Q.

## Interface
- WIDTH, 4, number of JK cells and the data/count width (≥1)
- RST_VAL, 0, WIDTH-bit value loaded into Q on reset
- WRAP, 1, 1 = counter wraps at terminal count; 0 = counter saturates at terminal count

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  cycle enable; when 0, all cells hold
- mode  input  2  00 JK, 01 count up, 10 count down, 11 parallel load
- J  input  WIDTH  per-bit J (mode 00 only)
- K  input  WIDTH  per-bit K (mode 00 only)
- D  input  WIDTH  parallel load data (mode 11 only)
- Q  output  WIDTH  registered state
- Qbar  output  WIDTH  registered complement, always ~Q
- tc  output  1  terminal count, combinational from Q and mode

## Operation
- Priority at each rising clk: rst > !en > mode.
- rst=1: Q←RST_VAL, Qbar←~RST_VAL, regardless of en or mode.
- en=0: all cells hold.
- mode 00, per bit i:
  - J=0, K=0: hold.
  - J=0, K=1: clear.
  - J=1, K=0: set.
  - J=1, K=1: toggle.
- mode 01 (up): bit i receives J=K=1 when bits [i-1:0] are all 1; bit 0 always toggles. Net effect: Q←Q+1 mod 2^WIDTH.
- mode 10 (down): bit i receives J=K=1 when bits [i-1:0] are all 0. Net effect: Q←Q−1 mod 2^WIDTH.
- mode 11 (load): bit i receives J=D[i], K=~D[i]. Net effect: Q←D.
- Terminal count:
  - tc=1 in mode 01 when Q is all ones; tc=1 in mode 10 when Q is all zeros; tc=0 in modes 00 and 11.
  - tc does not depend on en.
- WRAP=0: in count modes, all cells receive J=K=0 while tc=1, so the counter sticks at the terminal value.
  - Loading, JK mode or reset still leaves saturation.
- In modes 00, 01 and 10, inputs not used by the current mode (J, K, D) are ignored.
- Mode may change on any cycle. The new mode takes effect on the same edge; there is no pipelining of mode.

## Timing
- State latency is 1 cycle: inputs sampled at edge n appear on Q/Qbar after edge n.
- tc is combinational from the current Q and mode. It must not be registered, so it is valid in the same cycle as Q.
- Qbar is never derived from separate next-state logic. Each cell computes its next Q once, and Qbar is its complement. Q and Qbar may never be equal, including on the first cycle after reset.
- Before the first reset, state is unspecified. The bench applies rst before checking anything.
- Reset asserted during counting takes effect on that edge; the count is discarded.
- Wrap cases (WRAP=1):
  - Up from 2^WIDTH−1 goes to 0.
  - Down from 0 goes to 2^WIDTH−1.

## Structure
- Shared package jk_pkg holds the mode encoding constants: MODE_JK=2'b00, MODE_UP=2'b01, MODE_DN=2'b10, MODE_LD=2'b11.
- Sub-module jk_ff_cell: one bit with clk, rst, en, j, k, rst_val inputs and q, qbar outputs.
  - Contains the synchronous reset and the enable.
  - jk_counter_reg instantiates WIDTH cells in a generate loop.
- Top-level logic is limited to:
  - the per-mode J/K steering muxes;
  - the lower-bit all-ones/all-zeros carry chains;
  - the tc/saturation logic.

## Test plan
- Reset: WIDTH=4, RST_VAL=4'b1010, rst=1 for 1 edge -> Q=1010, Qbar=0101. Repeat with en=0 -> same result.
- JK truth table: Q=0110, J=0011, K=0101, mode 00 -> bit0 toggles, bit1 sets, bit2 clears, bit3 holds. Expect Q=0011, Qbar=1100.
- Up count with wrap: load 4'hD, then 4 edges in mode 01 -> Q sequence E, F, 0, 1. tc=1 only while Q=F.
- Down count with WRAP=0: load 4'h2, then 4 edges in mode 10 -> Q sequence 1, 0, 0, 0. tc=1 from Q=0 onward. Then load 4'h5 -> Q=5.
- Enable and mid-count reset: counting up from 3, en=0 for 2 edges -> Q holds at 3. Then en=1 with rst=1 on the next edge -> Q=RST_VAL.
- Randomised: 1000 cycles of random mode, en, J, K, D and sparse rst, compared against a reference model each edge. Check Qbar==~Q and tc on every cycle.
